// File: rtl/uart_receiver.sv
// uart_receiver -- 8N1 (or 8E1) UART receive path, LSB first.
//
// Samples the asynchronous rx line through a 2-flop synchronizer. It checks
// the start bit at half a bit time, then samples each data bit (and the
// parity bit, if compiled in) and the stop bit at mid-bit. Each good byte is
// presented with a one-cycle data_valid strobe.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> 8E1 frame, PARITY state compiled in, parity_err live
//   undefined -> 8N1 frame, parity_err tied to 0
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   rx         in   serial line (asynchronous, idles high)
//   data       out  [7:0] last good received byte
//   data_valid out  one-cycle strobe, data is new in that cycle
//   frame_err  out  one-cycle strobe, stop bit sampled low
//   parity_err out  one-cycle strobe, even-parity mismatch (macro only)
//   busy       out  high whenever the receiver is not idle

module uart_receiver #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state_reg;
  logic [1:0]       sync_reg;
  logic             rx_s;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;

  // Synchronizer flops reset to 1 so that reset release never looks like
  // a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rx};
    end
  end

  assign rx_s = sync_reg[1];

`ifdef UART_RX_PARITY_EN
  logic par_bad_reg;
  logic parity_err_reg;
  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= 3'd0;
      shift_reg   <= 8'h00;
      data        <= 8'h00;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_reg    <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      // Strobes default low so each one lasts exactly one cycle.
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (!rx_s) begin
            state_reg <= START;
            busy      <= 1'b1;
          end
        end

        // Re-check the start bit at its middle. A high line here means the
        // falling edge was a glitch.
        START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg     <= '0;
            bit_idx_reg <= 3'd0;
            if (rx_s) begin
              state_reg <= IDLE;
              busy      <= 1'b0;
            end else begin
              state_reg <= DATA;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        DATA: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg     <= '0;
            shift_reg   <= {rx_s, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 1'b1;
            if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_reg <= PARITY;
`else
              state_reg <= STOP;
`endif
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        // Even parity: the parity bit XOR all data bits must be 0.
        PARITY: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg     <= '0;
            par_bad_reg <= rx_s ^ (^shift_reg);
            state_reg   <= STOP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
`endif

        STOP: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg <= '0;
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              if (par_bad_reg) begin
                parity_err_reg <= 1'b1;
              end else begin
                data       <= shift_reg;
                data_valid <= 1'b1;
              end
`else
              data       <= shift_reg;
              data_valid <= 1'b1;
`endif
              state_reg <= IDLE;
              busy      <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state_reg <= WAIT_HIGH;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        // A held-low line (break) must not restart reception.
        WAIT_HIGH: begin
          if (rx_s) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Testbench for uart_receiver with CLKS_PER_BIT = 16.
module tb_uart_receiver;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int EXTRA = CPB;
`else
  localparam int EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Strobe monitor: counts every high cycle of each strobe.
  int         edge_cnt = 0;
  int         dv_cnt = 0;
  int         fe_cnt = 0;
  int         pe_cnt = 0;
  int         excl_cnt = 0;
  int         dv_edge = 0;
  logic [7:0] bytes_seen [0:63];
  int         t0_edge = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid) begin
        bytes_seen[dv_cnt[5:0]] <= data;
        dv_cnt  <= dv_cnt + 1;
        dv_edge <= edge_cnt;
      end
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (parity_err) pe_cnt <= pe_cnt + 1;
      if (32'(data_valid) + 32'(frame_err) + 32'(parity_err) > 1) excl_cnt <= excl_cnt + 1;
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Called at a negedge; t0 is the next rising edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    t0_edge = edge_cnt + 1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    drive_bit(stop_bit);
    if (stop_bit) rx = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rx = i[0];
      @(negedge clk);
      checks++;
      if ({data, data_valid, frame_err, parity_err, busy} !== 12'h000) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: data=%h dv=%b fe=%b pe=%b busy=%b, required all 0",
                 i, data, data_valid, frame_err, parity_err, busy);
      end
    end
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if ({data, data_valid, frame_err, parity_err, busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_release: data=%h dv=%b fe=%b pe=%b busy=%b, required all 0",
               data, data_valid, frame_err, parity_err, busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_frame();
    int d0, f0, p0, lat;
    d0 = dv_cnt; f0 = fe_cnt; p0 = pe_cnt;
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (dv_cnt - d0 != 1) begin
      errors++;
      $display("FAIL single_count: got %0d data_valid cycles, required 1", dv_cnt - d0);
    end
    checks++;
    if (bytes_seen[d0[5:0]] !== 8'hA5 || data !== 8'hA5) begin
      errors++;
      $display("FAIL single_data: strobed=%h held=%h, required a5", bytes_seen[d0[5:0]], data);
    end
    // Latency is the edge at which a downstream flop captures the strobe.
    lat = dv_edge - t0_edge + 1;
    checks++;
    if (lat < 155 + EXTRA || lat > 157 + EXTRA) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles, required %0d..%0d", lat, 155 + EXTRA, 157 + EXTRA);
    end
    checks++;
    if (fe_cnt != f0 || pe_cnt != p0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_errs: fe=%0d pe=%0d busy=%b, required 0 0 0", fe_cnt - f0, pe_cnt - p0, busy);
    end
    $display("test_single_frame: byte a5 latency %0d", lat);
  endtask

  task automatic test_back_to_back();
    int d0;
    logic [7:0] exp_b [0:2];
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
    d0 = dv_cnt;
    for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (dv_cnt - d0 != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d data_valid cycles, required 3", dv_cnt - d0);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bytes_seen[6'(d0 + i)] !== exp_b[i]) begin
        errors++;
        $display("FAIL b2b_byte%0d: got %h, required %h", i, bytes_seen[6'(d0 + i)], exp_b[i]);
      end
    end
    $display("test_back_to_back: 00 ff 3c sent");
  endtask

  task automatic test_glitch();
    int d0, f0, p0, n;
    d0 = dv_cnt; f0 = fe_cnt; p0 = pe_cnt;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy_rise: busy=%b, required 1", busy);
    end
    n = 0;
    while (busy !== 1'b0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy_fall: busy=%b after %0d cycles, required 0", busy, n);
    end
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (dv_cnt != d0 || fe_cnt != f0 || pe_cnt != p0) begin
      errors++;
      $display("FAIL glitch_strobe: dv=%0d fe=%0d pe=%0d, required 0 0 0", dv_cnt - d0, fe_cnt - f0, pe_cnt - p0);
    end
    $display("test_glitch: busy cleared after %0d cycles", n);
  endtask

  task automatic test_frame_error();
    int d0, f0, n;
    d0 = dv_cnt; f0 = fe_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (40 - CPB) @(negedge clk);
    #1;
    checks++;
    if (fe_cnt - f0 != 1 || dv_cnt != d0) begin
      errors++;
      $display("FAIL ferr_count: fe=%0d dv=%0d, required 1 0", fe_cnt - f0, dv_cnt - d0);
    end
    checks++;
    if (data !== 8'h3C) begin
      errors++;
      $display("FAIL ferr_data: got %h, required 3c", data);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL ferr_busy_hold: busy=%b, required 1 while line low", busy);
    end
    rx = 1'b1;
    n = 0;
    while (busy !== 1'b0 && n < 6) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ferr_busy_fall: busy=%b after %0d cycles, required 0", busy, n);
    end
    repeat (CPB) @(negedge clk);
    $display("test_frame_error: byte 55 stop low, busy cleared after %0d cycles", n);
  endtask

  task automatic test_midframe_reset();
    int d0, f0, p0;
    logic [7:0] b;
    b = 8'hC3;
    d0 = dv_cnt; f0 = fe_cnt; p0 = pe_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx = b[4];
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({data, data_valid, frame_err, parity_err, busy} !== 12'h000) begin
      errors++;
      $display("FAIL midreset_outputs: data=%h dv=%b fe=%b pe=%b busy=%b, required all 0",
               data, data_valid, frame_err, parity_err, busy);
    end
    repeat (3) @(negedge clk);
    rx = 1'b1;
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    #1;
    checks++;
    if (dv_cnt != d0 || fe_cnt != f0 || pe_cnt != p0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_quiet: dv=%0d fe=%0d pe=%0d busy=%b, required 0 0 0 0",
               dv_cnt - d0, fe_cnt - f0, pe_cnt - p0, busy);
    end
    send_frame(8'h81, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (dv_cnt - d0 != 1 || data !== 8'h81) begin
      errors++;
      $display("FAIL midreset_next: dv=%0d data=%h, required 1 81", dv_cnt - d0, data);
    end
    $display("test_midframe_reset: c3 aborted, 81 received");
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int d0, p0;
    d0 = dv_cnt; p0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (dv_cnt - d0 != 1 || data !== 8'h07 || pe_cnt != p0) begin
      errors++;
      $display("FAIL parity_good: dv=%0d data=%h pe=%0d, required 1 07 0", dv_cnt - d0, data, pe_cnt - p0);
    end
    d0 = dv_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (pe_cnt - p0 != 1 || dv_cnt != d0 || data !== 8'h07) begin
      errors++;
      $display("FAIL parity_bad: pe=%0d dv=%0d data=%h, required 1 0 07", pe_cnt - p0, dv_cnt - d0, data);
    end
    $display("test_parity: 07 good and bad parity sent");
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_midframe_reset();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    checks++;
    if (excl_cnt != 0 || (EXTRA == 0 && pe_cnt != 0)) begin
      errors++;
      $display("FAIL strobe_exclusive: overlap cycles=%0d parity_err cycles=%0d, required 0 0", excl_cnt, pe_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
